// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: hold/load/shift/rotate/clear plus a counted burst engine.
// Optional `USR_PARITY_EN adds a registered even-parity output that tracks q.
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROTL = 3'b100;
    localparam logic [2:0] M_ROTR = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             burst_mode;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] nxt;
        case (op)
            M_LOAD:  nxt = din;
            M_SHL:   nxt = {cur[WIDTH-2:0], sr};
            M_SHR:   nxt = {sl, cur[WIDTH-1:1]};
            M_ROTL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROTR:  nxt = {cur[0], cur[WIDTH-1:1]};
            M_CLR:   nxt = '0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    assign burst_mode = (mode >= M_SHL) && (mode <= M_ROTR);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && burst_mode) begin
                        mode_d = mode;
                        if (burst_len == '0) begin
                            cnt_d  = '0;
                            done_d = 1'b1;
                        end else begin
                            // First step happens on the start edge, so the counter holds remaining steps.
                            q_d   = apply_op(mode, q_q, d, sin_l, sin_r);
                            cnt_d = burst_len - CNT_W'(1);
                            if (burst_len == CNT_W'(1)) begin
                                done_d = 1'b1;
                            end else begin
                                busy_d  = 1'b1;
                                state_d = ST_BURST;
                            end
                        end
                    end else begin
                        q_d = apply_op(mode, q_q, d, sin_l, sin_r);
                    end
                end
                default: begin
                    q_d   = apply_op(mode_q, q_q, d, sin_l, sin_r);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef USR_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = ^q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

    assign q        = q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8) against an arithmetic reference model.
// Directed scenarios followed by randomized traffic; parity checks are active under USR_PARITY_EN.
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          sin_l;
    logic          sin_r;
    logic          start;
    logic [CW-1:0] burst_len;
    logic [W-1:0]  q;
    logic          sout_msb;
    logic          sout_lsb;
    logic          busy;
    logic          done;
`ifdef USR_PARITY_EN
    logic          parity;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: register value, steps still owed by a burst, latched op.
    logic [W-1:0] m_q;
    int           m_rem;
    int           m_op;
    logic         m_busy;
    logic         m_done;

    int busy_cnt;
    int done_cnt;

    universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .start     (start),
        .burst_len (burst_len),
        .q         (q),
        .sout_msb  (sout_msb),
        .sout_lsb  (sout_lsb),
        .busy      (busy),
        .done      (done)
`ifdef USR_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] cur,
                                            input logic [W-1:0] din, input logic sl, input logic sr);
        int unsigned v;
        int unsigned r;
        v = cur;
        case (op)
            1:       r = din;
            2:       r = v * 2 + (sr ? 1 : 0);
            3:       r = v / 2 + (sl ? 128 : 0);
            4:       r = v * 2 + v / 128;
            5:       r = v / 2 + (v % 2) * 128;
            6:       r = 0;
            default: r = v;
        endcase
        return r[W-1:0];
    endfunction

    task automatic model_reset();
        m_q    = '0;
        m_rem  = 0;
        m_op   = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_step();
        int len;
        len = int'(burst_len);
        if (!rst_n) begin
            model_reset();
        end else if (!en) begin
            m_done = 1'b0;
        end else if (m_rem > 0) begin
            m_q    = ref_op(m_op, m_q, d, sin_l, sin_r);
            m_rem  = m_rem - 1;
            m_done = (m_rem == 0);
            m_busy = (m_rem > 0);
        end else if (start && mode >= 3'd2 && mode <= 3'd5) begin
            m_op = int'(mode);
            if (len == 0) begin
                m_done = 1'b1;
            end else begin
                m_q    = ref_op(m_op, m_q, d, sin_l, sin_r);
                m_rem  = len - 1;
                m_done = (m_rem == 0);
                m_busy = (m_rem > 0);
            end
        end else begin
            m_q    = ref_op(int'(mode), m_q, d, sin_l, sin_r);
            m_done = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".msb"}, 32'(sout_msb), 32'(m_q[W-1]));
        chk({tag, ".lsb"}, 32'(sout_lsb), 32'(m_q[0]));
`ifdef USR_PARITY_EN
        chk({tag, ".par"}, 32'(parity), 32'(^m_q));
`endif
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
        busy_cnt += int'(busy);
        done_cnt += int'(done);
    endtask

    task automatic op1(input logic [2:0] m, input logic [W-1:0] dv, input string tag);
        en    = 1'b1;
        start = 1'b0;
        mode  = m;
        d     = dv;
        cycle(tag);
    endtask

    task automatic burst(input logic [2:0] m, input int len, input string tag);
        en        = 1'b1;
        start     = 1'b1;
        mode      = m;
        burst_len = CW'(len);
        cycle(tag);
        start     = 1'b0;
        mode      = 3'b000;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = '0; d = '0;
        sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; burst_len = '0;
        busy_cnt = 0; done_cnt = 0;
        model_reset();

        // 1. reset then load
        cycle("rst0");
        cycle("rst1");
        chk("reset_q", 32'(q), 32'h00);
        rst_n = 1'b1;
        op1(3'b001, 8'hA5, "load");
        chk("load_a5", 32'(q), 32'hA5);
        en = 1'b0; d = 8'hFF;
        cycle("en_off");
        chk("en_off_q", 32'(q), 32'hA5);

        // 2. single ops from A5
        op1(3'b100, 8'h00, "rotl");
        chk("rotl_a5", 32'(q), 32'h4B);
        op1(3'b001, 8'hA5, "ld");
        op1(3'b101, 8'h00, "rotr");
        chk("rotr_a5", 32'(q), 32'hD2);
        op1(3'b001, 8'hA5, "ld");
        sin_r = 1'b1;
        op1(3'b010, 8'h00, "shl");
        chk("shl_a5", 32'(q), 32'h4B);
        op1(3'b001, 8'hA5, "ld");
        sin_l = 1'b0;
        op1(3'b011, 8'h00, "shr");
        chk("shr_a5", 32'(q), 32'h52);
        op1(3'b111, 8'hFF, "rsvd");
        chk("rsvd_hold", 32'(q), 32'h52);
        op1(3'b110, 8'hFF, "clr");
        chk("clear", 32'(q), 32'h00);

        // 3. rotl burst of 3 from 81; mid-burst inputs must be ignored
        op1(3'b001, 8'h81, "ld81");
        busy_cnt = 0; done_cnt = 0;
        burst(3'b100, 3, "b3s");
        start = 1'b1; mode = 3'b001; d = 8'($urandom);
        cycle("b3a");
        start = 1'b0; mode = 3'b110;
        cycle("b3b");
        chk("burst3_q", 32'(q), 32'h0C);
        mode = 3'b000;
        cycle("b3c");
        chk("burst3_busy_cycles", 32'(busy_cnt), 32'd2);
        chk("burst3_done_pulses", 32'(done_cnt), 32'd1);

        // 4. burst length edges
        op1(3'b001, 8'h3C, "ld3c");
        busy_cnt = 0; done_cnt = 0;
        burst(3'b010, 0, "b0");
        chk("len0_q", 32'(q), 32'h3C);
        chk("len0_done", 32'(done), 32'd1);
        burst(3'b101, 1, "b1");
        chk("len1_q", 32'(q), 32'h1E);
        chk("len1_done", 32'(done), 32'd1);
        cycle("b1idle");
        chk("len01_busy_never", 32'(busy_cnt), 32'd0);
        op1(3'b001, 8'h01, "ld01");
        burst(3'b101, 9, "b9s");
        for (int i = 0; i < 8; i++) cycle("b9");
        chk("len9_rotr", 32'(q), 32'h80);

        // 5. stall mid-burst, then reset mid-burst
        op1(3'b001, 8'hFF, "ldff");
        sin_r = 1'b0;
        burst(3'b010, 4, "st0");
        cycle("st1");
        en = 1'b0;
        for (int i = 0; i < 3; i++) cycle("stall");
        chk("stall_q", 32'(q), 32'hFC);
        chk("stall_busy", 32'(busy), 32'd1);
        en = 1'b1;
        cycle("st2");
        cycle("st3");
        chk("stall_final", 32'(q), 32'hF0);
        op1(3'b001, 8'hFF, "ldff2");
        burst(3'b010, 4, "rb0");
        cycle("rb1");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_q", 32'(q), 32'h00);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_done", 32'(done), 32'd0);
        #1 rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) cycle("post_rst");
        chk("no_done_after_abort", 32'(done_cnt), 32'd0);

`ifdef USR_PARITY_EN
        op1(3'b001, 8'h07, "p07");
        chk("parity_07", 32'(parity), 32'd1);
        op1(3'b001, 8'h03, "p03");
        chk("parity_03", 32'(parity), 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            mode      = 3'($urandom_range(0, 7));
            d         = 8'($urandom);
            sin_l     = 1'($urandom);
            sin_r     = 1'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            burst_len = CW'($urandom_range(0, 10));
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
